// File: rtl/ps2_kbd_ctrl_if.sv
// Bus bundle between the PS/2 receiver FIFO, the key-event consumer and
// the ps2_kbd_ctrl sequencer. The controller uses the master modport; the
// surrounding logic (FIFO, consumer, status) uses the slave modport.
interface ps2_kbd_ctrl_if;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_overflow;
  logic       fifo_rd;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [3:0] mods;
  logic       err;
  logic       err_clr;

  modport master (
    input  fifo_data, fifo_empty, fifo_overflow, ev_ready, err_clr,
    output fifo_rd, ev_valid, ev_code, ev_ext, ev_break, mods, err
  );

  modport slave (
    output fifo_data, fifo_empty, fifo_overflow, ev_ready, err_clr,
    input  fifo_rd, ev_valid, ev_code, ev_ext, ev_break, mods, err
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard scan-code sequencer: pops bytes from the receiver FIFO,
// parses E0/F0/E1 prefixes, tracks modifier keys and emits one make/break
// event per complete scan sequence on a valid/ready port.
// Optional build macro PS2_KBD_CTRL_REPEAT_FILTER_EN: suppress typematic
// repeats of the most recent make until that key is released.
//
// state   | meaning
// BASE    | idle, waiting for the first byte of a sequence
// EXT     | E0 seen, next byte is an extended code or F0
// BRK     | F0 seen, next byte is the released key
// EXT_BRK | E0 F0 seen, next byte is the released extended key
// SKIP    | E1 seen, swallowing the rest of the Pause sequence
module ps2_kbd_ctrl #(
  parameter int TIMEOUT_CYCLES = 54000,
  parameter int TO_W           = 16
) (
  input  logic            clock_27mhz,
  input  logic            reset,
  ps2_kbd_ctrl_if.master  bus
);

  typedef enum logic [2:0] {BASE, EXT, BRK, EXT_BRK, SKIP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [2:0]      skip_cnt, skip_nxt;
  logic [TO_W-1:0] to_cnt;

  logic       ev_valid_q, ev_ext_q, ev_break_q, err_q;
  logic [7:0] ev_code_q;
  logic       held_l12, held_r59, held_lctrl, held_rctrl;
  logic       held_lalt, held_ralt, held_58, caps_q;

  logic       pop, take, suppress;
  logic       dec_emit, dec_ext, dec_brk;
  logic [7:0] dec_code;

  // A pop is only issued when the output slot is free or being drained.
  assign pop  = ~reset & ~bus.fifo_empty & (~ev_valid_q | bus.ev_ready);
  assign take = pop & ~bus.fifo_overflow;

  assign bus.fifo_rd  = pop;
  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_code  = ev_code_q;
  assign bus.ev_ext   = ev_ext_q;
  assign bus.ev_break = ev_break_q;
  assign bus.err      = err_q;
  assign bus.mods     = {caps_q, held_lalt | held_ralt, held_lctrl | held_rctrl,
                         held_l12 | held_r59};

  // Decode the FIFO head byte against the current parser state.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    dec_emit  = 1'b0;
    dec_code  = bus.fifo_data;
    dec_ext   = 1'b0;
    dec_brk   = 1'b0;
    case (state)
      BASE: begin
        case (bus.fifo_data)
          8'hE0: state_nxt = EXT;
          8'hF0: state_nxt = BRK;
          8'hE1: begin
            state_nxt = SKIP;
            skip_nxt  = 3'd7;
          end
          8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_nxt = BASE;
          default: dec_emit = 1'b1;
        endcase
      end
      EXT: begin
        if (bus.fifo_data == 8'hF0) begin
          state_nxt = EXT_BRK;
        end else begin
          state_nxt = BASE;
          // E0 12 / E0 59 are fake-shift bytes around extended keys.
          if (bus.fifo_data != 8'h12 && bus.fifo_data != 8'h59) begin
            dec_emit = 1'b1;
            dec_ext  = 1'b1;
          end
        end
      end
      BRK: begin
        state_nxt = BASE;
        dec_emit  = 1'b1;
        dec_brk   = 1'b1;
      end
      EXT_BRK: begin
        state_nxt = BASE;
        if (bus.fifo_data != 8'h12 && bus.fifo_data != 8'h59) begin
          dec_emit = 1'b1;
          dec_ext  = 1'b1;
          dec_brk  = 1'b1;
        end
      end
      SKIP: begin
        skip_nxt = skip_cnt - 3'd1;
        if (skip_cnt == 3'd1) begin
          state_nxt = BASE;
          dec_emit  = 1'b1;
          dec_code  = 8'hE1;
        end
      end
      default: state_nxt = BASE;
    endcase
  end

`ifdef PS2_KBD_CTRL_REPEAT_FILTER_EN
  logic [8:0] last_make;
  logic       last_vld;

  assign suppress = dec_emit & ~dec_brk & last_vld & (last_make == {dec_ext, dec_code});

  // Remember the last emitted make; its own break re-arms it.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      last_make <= 9'd0;
      last_vld  <= 1'b0;
    end else if (take & dec_emit) begin
      if (!dec_brk) begin
        last_make <= {dec_ext, dec_code};
        last_vld  <= 1'b1;
      end else if (last_make == {dec_ext, dec_code}) begin
        last_vld <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // Parser state, prefix timeout, event register and sticky error.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      state      <= BASE;
      skip_cnt   <= 3'd0;
      to_cnt     <= '0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= 8'h00;
      ev_ext_q   <= 1'b0;
      ev_break_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (bus.err_clr) err_q <= 1'b0;

      if (bus.fifo_overflow) begin
        state  <= BASE;
        to_cnt <= '0;
        err_q  <= 1'b1;
      end else if (pop) begin
        state    <= state_nxt;
        skip_cnt <= skip_nxt;
        to_cnt   <= '0;
      end else if (state != BASE) begin
        if (to_cnt == TO_LAST) begin
          state  <= BASE;
          to_cnt <= '0;
          err_q  <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end

      if (take & dec_emit & ~suppress) begin
        ev_valid_q <= 1'b1;
        ev_code_q  <= dec_code;
        ev_ext_q   <= dec_ext;
        ev_break_q <= dec_brk;
      end else if (bus.ev_ready) begin
        ev_valid_q <= 1'b0;
      end
    end
  end

  // Held-key flags and caps-lock toggle, updated on every decoded key.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      held_l12   <= 1'b0;
      held_r59   <= 1'b0;
      held_lctrl <= 1'b0;
      held_rctrl <= 1'b0;
      held_lalt  <= 1'b0;
      held_ralt  <= 1'b0;
      held_58    <= 1'b0;
      caps_q     <= 1'b0;
    end else if (take & dec_emit) begin
      case ({dec_ext, dec_code})
        9'h012: held_l12   <= ~dec_brk;
        9'h059: held_r59   <= ~dec_brk;
        9'h014: held_lctrl <= ~dec_brk;
        9'h114: held_rctrl <= ~dec_brk;
        9'h011: held_lalt  <= ~dec_brk;
        9'h111: held_ralt  <= ~dec_brk;
        9'h058: begin
          // Typematic repeats of caps lock arrive while held_58 is set.
          if (!dec_brk && !held_58) caps_q <= ~caps_q;
          held_58 <= ~dec_brk;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a queue models the receiver FIFO and a
// scoreboard of expected events is filled as bytes are queued and drained
// at each valid/ready handshake.
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;

  typedef struct packed {
    logic [3:0] mods;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ev_t;

  logic clock_27mhz = 1'b0;
  logic reset       = 1'b1;

  ps2_kbd_ctrl_if bus ();

  ps2_kbd_ctrl #(.TIMEOUT_CYCLES(54000), .TO_W(16)) dut (
    .clock_27mhz (clock_27mhz),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 clock_27mhz = ~clock_27mhz;

  logic [7:0] fifo_q[$];
  ev_t        sb[$];
  int         vectors    = 0;
  int         miscompares = 0;
  int         hs_cnt     = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input logic [7:0] c, input logic e, input logic b,
                             input logic [3:0] m);
    ev_t r;
    r.mods = m;
    r.brk  = b;
    r.ext  = e;
    r.code = c;
    return r;
  endfunction

  task automatic update_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
    update_fifo();
  endtask

  task automatic expect_ev(input logic [7:0] c, input logic e, input logic b,
                           input logic [3:0] m);
    sb.push_back(mk(c, e, b, m));
  endtask

  task automatic tick();
    logic       rd, hs;
    logic [7:0] drop;
    ev_t        obs, exp;
    @(negedge clock_27mhz);
    rd  = bus.fifo_rd;
    hs  = bus.ev_valid & bus.ev_ready;
    obs = mk(bus.ev_code, bus.ev_ext, bus.ev_break, bus.mods);
    @(posedge clock_27mhz);
    #1;
    if (rd === 1'b1 && fifo_q.size() != 0) drop = fifo_q.pop_front();
    update_fifo();
    if (hs === 1'b1) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_event", 16'(obs), 16'hFFFF);
      end else begin
        exp = sb.pop_front();
        check("event", 16'(obs), 16'(exp));
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_q.size() != 0 || bus.ev_valid === 1'b1) && n < 300) begin
      tick();
      n++;
    end
    run(3);
    check("drain_idle", 16'(fifo_q.size() != 0 || bus.ev_valid !== 1'b0), 16'd0);
    check("sb_empty", 16'(sb.size()), 16'd0);
  endtask

  task automatic send_ovf(input logic [7:0] b);
    bus.fifo_overflow = 1'b1;
    send(b);
    tick();
    bus.fifo_overflow = 1'b0;
  endtask

  initial begin
    bus.fifo_overflow = 1'b0;
    bus.ev_ready      = 1'b1;
    bus.err_clr       = 1'b0;
    update_fifo();

    // Reset: no pops even with data waiting, outputs cleared.
    run(3);
    send(8'h1C);
    tick();
    check("rst_fifo_rd", 16'(bus.fifo_rd), 16'd0);
    check("rst_ev_valid", 16'(bus.ev_valid), 16'd0);
    check("rst_ev_code", 16'(bus.ev_code), 16'd0);
    check("rst_mods", 16'(bus.mods), 16'd0);
    check("rst_err", 16'(bus.err), 16'd0);
    fifo_q.delete();
    update_fifo();
    reset = 1'b0;
    run(2);

    // Simple make/break with one-cycle latency.
    hs_cnt = 0;
    expect_ev(8'h1C, 1'b0, 1'b0, 4'b0000);
    send(8'h1C);
    tick();
    check("lat_valid", 16'(bus.ev_valid), 16'd1);
    check("lat_code", 16'(bus.ev_code), 16'h1C);
    expect_ev(8'h1C, 1'b0, 1'b1, 4'b0000);
    send(8'hF0); send(8'h1C);
    drain();
    check("pulse_count", 16'(hs_cnt), 16'd2);

    // Extended make/break and fake shift.
    hs_cnt = 0;
    expect_ev(8'h75, 1'b1, 1'b0, 4'b0000);
    expect_ev(8'h75, 1'b1, 1'b1, 4'b0000);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h12);
    drain();
    check("ext_count", 16'(hs_cnt), 16'd2);

    // Shift and caps lock with a typematic repeat.
    expect_ev(8'h12, 1'b0, 1'b0, 4'b0001);
    expect_ev(8'h58, 1'b0, 1'b0, 4'b1001);
`ifndef PS2_KBD_CTRL_REPEAT_FILTER_EN
    expect_ev(8'h58, 1'b0, 1'b0, 4'b1001);
`endif
    send(8'h12); send(8'h58); send(8'h58);
    drain();
    check("caps_after_repeat", 16'(bus.mods), 16'b1001);
    expect_ev(8'h58, 1'b0, 1'b1, 4'b1001);
    expect_ev(8'h58, 1'b0, 1'b0, 4'b0001);
    expect_ev(8'h12, 1'b0, 1'b1, 4'b0000);
    send(8'hF0); send(8'h58); send(8'h58);
    send(8'hF0); send(8'h12);
    drain();
    check("caps_off", 16'(bus.mods), 16'b0000);

    // Ctrl and alt, left and right, plus right shift.
    expect_ev(8'h14, 1'b0, 1'b0, 4'b0010);
    expect_ev(8'h14, 1'b1, 1'b0, 4'b0010);
    expect_ev(8'h14, 1'b0, 1'b1, 4'b0010);
    expect_ev(8'h14, 1'b1, 1'b1, 4'b0000);
    expect_ev(8'h11, 1'b1, 1'b0, 4'b0100);
    expect_ev(8'h59, 1'b0, 1'b0, 4'b0101);
    expect_ev(8'h59, 1'b0, 1'b1, 4'b0100);
    expect_ev(8'h11, 1'b1, 1'b1, 4'b0000);
    send(8'h14); send(8'hE0); send(8'h14);
    send(8'hF0); send(8'h14); send(8'hE0); send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h11); send(8'h59); send(8'hF0); send(8'h59);
    send(8'hE0); send(8'hF0); send(8'h11);
    drain();

    // Pause: E1 plus seven bytes gives exactly one event.
    hs_cnt = 0;
    expect_ev(8'hE1, 1'b0, 1'b0, 4'b0000);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    drain();
    check("pause_count", 16'(hs_cnt), 16'd1);
    check("pause_mods", 16'(bus.mods), 16'd0);

    // Prefix timeout.
    send(8'hE0);
    tick();
    run(53990);
    check("to_before", 16'(bus.err), 16'd0);
    run(20);
    check("to_after", 16'(bus.err), 16'd1);
    expect_ev(8'h1C, 1'b0, 1'b0, 4'b0000);
    send(8'h1C);
    drain();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("err_clr", 16'(bus.err), 16'd0);

    // Backpressure: one event held, remaining bytes stay queued.
    bus.ev_ready = 1'b0;
    expect_ev(8'h1C, 1'b0, 1'b0, 4'b0000);
    expect_ev(8'h32, 1'b0, 1'b0, 4'b0000);
    expect_ev(8'h21, 1'b0, 1'b0, 4'b0000);
    send(8'h1C); send(8'h32); send(8'h21);
    tick();
    check("bp_valid", 16'(bus.ev_valid), 16'd1);
    check("bp_code0", 16'(bus.ev_code), 16'h1C);
    run(5);
    check("bp_fifo_rd", 16'(bus.fifo_rd), 16'd0);
    check("bp_hold_code", 16'(bus.ev_code), 16'h1C);
    check("bp_queued", 16'(fifo_q.size()), 16'd2);
    bus.ev_ready = 1'b1;
    tick();
    bus.ev_ready = 1'b0;
    check("bp_nobubble_valid", 16'(bus.ev_valid), 16'd1);
    check("bp_nobubble_code", 16'(bus.ev_code), 16'h32);
    run(3);
    check("bp_hold_code2", 16'(bus.ev_code), 16'h32);
    bus.ev_ready = 1'b1;
    drain();

    // Overflow drops the byte, sets err, keeps mods, aborts a prefix.
    expect_ev(8'h12, 1'b0, 1'b0, 4'b0001);
    send(8'h12);
    drain();
    send_ovf(8'h1C);
    check("ovf_err", 16'(bus.err), 16'd1);
    check("ovf_no_event", 16'(bus.ev_valid), 16'd0);
    check("ovf_mods", 16'(bus.mods), 16'b0001);
    send(8'hE0);
    tick();
    send_ovf(8'h75);
    expect_ev(8'h1C, 1'b0, 1'b0, 4'b0001);
    send(8'h1C);
    drain();
    bus.err_clr       = 1'b1;
    bus.fifo_overflow = 1'b1;
    tick();
    bus.fifo_overflow = 1'b0;
    check("err_set_wins", 16'(bus.err), 16'd1);
    tick();
    bus.err_clr = 1'b0;
    check("err_clr2", 16'(bus.err), 16'd0);

    // Reset mid-sequence discards the pending E0.
    send(8'hE0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_mods", 16'(bus.mods), 16'd0);
    expect_ev(8'h75, 1'b0, 1'b0, 4'b0000);
    send(8'h75);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Sequencing controller between the PS/2 receiver FIFO and the rest of the design.
- Drains scan-code bytes from the FIFO and parses E0/F0/E1 prefix sequences with an FSM.
- Tracks modifier state and emits one key event per complete scan sequence on a valid/ready output.
- Feeds the ASCII/mapping logic and any game or UI logic that needs make/break events.

Parameters:
- TIMEOUT_CYCLES, 54000: clock_27mhz cycles of FIFO silence allowed inside a prefix sequence (~2 ms) before the parser abandons it.
- TO_W, 16: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock_27mhz  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- fifo_data  in  8  receiver FIFO head byte; valid whenever fifo_empty=0.
- fifo_empty  in  1  receiver FIFO empty flag.
- fifo_overflow  in  1  receiver FIFO overflow flag.
- fifo_rd  out  1  one-cycle pop request; the receiver advances on the next edge.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event.
- ev_code  out  8  base scan code; 8'hE1 for Pause.
- ev_ext  out  1  code was E0-prefixed.
- ev_break  out  1  1 = key release, 0 = press.
- mods  out  4  {caps_lock, alt, ctrl, shift}, updated in the same cycle as the event.
- err  out  1  sticky: overflow or abandoned sequence seen.
- err_clr  in  1  clears err.

Behaviour:
- Reset: fifo_rd=0, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, mods=0, err=0, all held-key flags=0, FSM=BASE, timeout counter=0. Reset mid-sequence discards any partial prefix.
- Pop rule: fifo_rd = ~fifo_empty & (~ev_valid | ev_ready). The byte is taken from fifo_data in the same cycle fifo_rd=1. Back-to-back pops are legal.
- Latency: an event-producing byte popped in cycle t gives ev_valid=1 at t+1.
- Output hold: ev_valid stays high and all ev_* fields stay stable until the edge where ev_ready=1. If ev_ready=1 and a new event byte is popped in the same cycle, the new event replaces the old one with no bubble.
- FSM states (one transition per popped byte):
  - BASE: E0 -> EXT; F0 -> BRK; E1 -> SKIP (skip count = 7); AA/FA/FE/EE/00/FF -> discard, stay BASE; any other byte -> make event, ext=0.
  - EXT: F0 -> EXT_BRK; 12 or 59 (fake shift) -> discard, go BASE; other -> make event, ext=1, go BASE.
  - BRK: any byte -> break event, ext=0, go BASE.
  - EXT_BRK: 12 or 59 -> discard, go BASE; other -> break event, ext=1, go BASE.
  - SKIP: decrement the skip count on each pop; when the count reaches 0, emit a make event with code E1, ext=0, and go BASE. No break event is emitted for Pause.
- Timeout: in EXT, BRK, EXT_BRK or SKIP, the counter increments on every cycle without a pop and clears on each pop. When it reaches TIMEOUT_CYCLES: go BASE, set err, emit nothing.
- Modifiers:
  - shift = held_L12 | held_R59.
  - ctrl: 14 sets/clears held_Lctrl, E0 14 sets/clears held_Rctrl.
  - alt: 11 sets/clears held_Lalt, E0 11 sets/clears held_Ralt.
  - Make sets the held flag; break clears it.
  - caps_lock toggles on a make of 58 only if held_58=0; held_58 is set on make and cleared on break, so typematic repeats do not retoggle.
  - Modifier keys also produce events.
- Overflow: in any cycle with fifo_overflow=1, the popped byte is discarded, err is set, FSM -> BASE, and no event is emitted. mods are preserved.
- err_clr: clears err on the next edge. If a set condition occurs in the same cycle, set wins.

Optional Feature:
- Macro: PS2_KBD_CTRL_REPEAT_FILTER_EN.
- Defined: a make event whose {ext, code} equals the last emitted make and has had no intervening break for that key is suppressed. The byte is still popped, modifier state is still updated, and no event is emitted.
- Undefined: every typematic repeat produces a make event.

Test Plan:
- Bytes 1C, F0, 1C with ev_ready=1 -> events {code=1C, ext=0, break=0} then {code=1C, ext=0, break=1}; exactly 2 ev_valid pulses, each 1 cycle after its final byte pop.
- Bytes E0 75, E0 F0 75 -> {75, ext=1, break=0}, {75, ext=1, break=1}; bytes E0 12 -> no event.
- Bytes 12, 58, 58, F0 58, 58 -> mods[0]=1 after the first event; caps_lock=1 after the first 58 and stays 1 through the repeat; 0 after the final 58.
- Byte E1, then 7 bytes -> exactly one event {E1, 0, 0}.
- Byte E0 with no further bytes for 54000 cycles -> FSM returns to BASE, err=1; a following 1C emits {1C, ext=0}.
- Hold ev_ready=0 with 3 bytes (1C 32 21) queued -> fifo_rd=0 after the first pop and ev_code stays 1C; pulse ev_ready -> 32 then 21 delivered in order. Overflow=1 during a pop -> byte dropped and err=1; err_clr -> err=0.
